// File: rtl/gpr_wb_scoreboard.sv
// General-purpose register file with a writeback receiver, two bypassed read ports
// and a per-register pending scoreboard that decode sets at issue and writeback clears.
module gpr_wb_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NR_REGS        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic                      wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0]     wb_wdata,
  input  logic                      iss_valid,
  input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
  output logic                      iss_ready,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic [DATA_WIDTH-1:0]     rs1_data,
  output logic                      rs1_busy,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0]     rs2_data,
  output logic                      rs2_busy,
  output logic [REG_ADDR_WIDTH:0]   pending_cnt
);

  localparam int DEPTH = 1 << REG_ADDR_WIDTH;
  localparam int CNT_W = REG_ADDR_WIDTH + 1;

  // Storage spans the full index space; entries at or above NR_REGS are never written
  // or set, so they stay at their reset value and fold away in synthesis.
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic wb_fire, wb_legal, clr_en, wr_en;
  logic iss_fire, iss_legal, set_en;
  logic cnt_inc, cnt_dec;

  function automatic logic idx_legal(input logic [REG_ADDR_WIDTH-1:0] a);
    return (a != '0) && (int'(a) < NR_REGS);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    r = c;
    if (inc && !dec) begin
      if (c != CNT_W'(NR_REGS - 1)) r = c + 1'b1;
    end else if (dec && !inc) begin
      if (c != '0) r = c - 1'b1;
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [REG_ADDR_WIDTH-1:0] a,
                                                      input logic byp,
                                                      input logic [DATA_WIDTH-1:0] byp_data,
                                                      input logic [DATA_WIDTH-1:0] stored);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    if (idx_legal(a)) r = byp ? byp_data : stored;
    return r;
  endfunction

  always_comb begin
    wb_ready  = ~rst;
    wb_fire   = wb_valid & wb_ready;
    wb_legal  = idx_legal(wb_waddr);
    clr_en    = wb_fire & wb_legal;
    wr_en     = clr_en & wb_wen;
    iss_legal = idx_legal(iss_rd);
    // A writeback retiring the same destination this cycle releases the WAW stall.
    iss_ready = ~rst & ~(iss_legal & busy_q[iss_rd] & ~(wb_fire & (wb_waddr == iss_rd)));
    iss_fire  = iss_valid & iss_ready;
    set_en    = iss_fire & iss_legal;
  end

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[wb_waddr] = 1'b0;
    if (set_en) busy_d[iss_rd] = 1'b1;
  end

  // Count only real transitions of the busy vector so the counter tracks its popcount.
  always_comb begin
    cnt_inc = set_en & ~busy_q[iss_rd];
    cnt_dec = clr_en & busy_q[wb_waddr] & ~(set_en & (iss_rd == wb_waddr));
    cnt_d   = cnt_step(cnt_q, cnt_inc, cnt_dec);
  end

  always_comb begin
    rs1_data = read_port(rs1_addr, wr_en & (wb_waddr == rs1_addr), wb_wdata, regs_q[rs1_addr]);
    rs2_data = read_port(rs2_addr, wr_en & (wb_waddr == rs2_addr), wb_wdata, regs_q[rs2_addr]);
    rs1_busy = idx_legal(rs1_addr) & busy_q[rs1_addr] & ~(wb_fire & (wb_waddr == rs1_addr));
    rs2_busy = idx_legal(rs2_addr) & busy_q[rs2_addr] & ~(wb_fire & (wb_waddr == rs2_addr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (wr_en) regs_q[wb_waddr] <= wb_wdata;
    end
  end

  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_gpr_wb_scoreboard.sv
// Randomized scoreboard bench for gpr_wb_scoreboard (RV32E configuration, so indices
// 16..31 exercise the out-of-range rules) against an array-based reference model.
module tb_gpr_wb_scoreboard;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid, wb_wen, iss_valid;
  logic [AW-1:0] wb_waddr, iss_rd, rs1_addr, rs2_addr;
  logic [DW-1:0] wb_wdata;
  logic          wb_ready, iss_ready, rs1_busy, rs2_busy;
  logic [DW-1:0] rs1_data, rs2_data;
  logic [AW:0]   pending_cnt;

  gpr_wb_scoreboard #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wen(wb_wen),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d1, d2;
    logic          b1, b2, wr, ir;
    logic [AW:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain arrays indexed by architectural register number.
  logic [DW-1:0] m_reg [32];
  bit            m_busy [32];

  function automatic bit legal(input int a);
    return (a != 0) && (a < NR);
  endfunction

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit wv, input bit we, input int wa, input logic [DW-1:0] wd,
                      input bit iv, input int rd, input int a1, input int a2, input bit chk_en);
    exp_t e;
    bit wfire, ird, ifire;
    int n;
    @(posedge clk);
    #1;
    rst = r; wb_valid = wv; wb_wen = we; wb_waddr = AW'(wa); wb_wdata = wd;
    iss_valid = iv; iss_rd = AW'(rd); rs1_addr = AW'(a1); rs2_addr = AW'(a2);

    wfire = wv && !r;
    e.wr  = !r;
    ird   = !r && !(legal(rd) && m_busy[rd] && !(wfire && wa == rd));
    e.ir  = ird;
    e.d1  = !legal(a1) ? '0 : (wfire && we && wa == a1) ? wd : m_reg[a1];
    e.d2  = !legal(a2) ? '0 : (wfire && we && wa == a2) ? wd : m_reg[a2];
    e.b1  = legal(a1) && m_busy[a1] && !(wfire && wa == a1);
    e.b2  = legal(a2) && m_busy[a2] && !(wfire && wa == a2);
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    e.cnt = (AW+1)'(n);
    if (chk_en) exp_q.push_back(e);

    ifire = iv && ird;
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    end else begin
      if (wfire && legal(wa)) begin
        if (we) m_reg[wa] = wd;
        m_busy[wa] = 0;
      end
      if (ifire && legal(rd)) m_busy[rd] = 1;
    end
  endtask

  task automatic idle(input int a1, input int a2);
    step(0, 0, 0, 0, '0, 0, 0, a1, a2, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("wb_ready",    DW'(wb_ready),    DW'(e.wr));
        cmp("iss_ready",   DW'(iss_ready),   DW'(e.ir));
        cmp("rs1_data",    rs1_data,         e.d1);
        cmp("rs2_data",    rs2_data,         e.d2);
        cmp("rs1_busy",    DW'(rs1_busy),    DW'(e.b1));
        cmp("rs2_busy",    DW'(rs2_busy),    DW'(e.b2));
        cmp("pending_cnt", DW'(pending_cnt), DW'(e.cnt));
      end
    end
  end

  initial begin : driver
    rst = 1'b1; wb_valid = 0; wb_wen = 0; wb_waddr = '0; wb_wdata = '0;
    iss_valid = 0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 0; end

    step(1, 0, 0, 0, '0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, '0, 0, 0, 0, 0, 1);
    for (int a = 0; a < 32; a++) idle(a, 31 - a);

    // issue 5, bypassed writeback of 5, then stored value
    step(0, 0, 0, 0, '0, 1, 5, 5, 0, 1);
    idle(5, 5);
    step(0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 1);
    idle(5, 5);

    // index 0 writes and issues
    step(0, 1, 1, 0, 32'h12345678, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, '0, 1, 0, 0, 0, 1);
    idle(0, 0);

    // WAW stall on 7, then release by same-cycle writeback
    step(0, 0, 0, 0, '0, 1, 7, 7, 0, 1);
    step(0, 0, 0, 0, '0, 1, 7, 7, 0, 1);
    step(0, 1, 1, 7, 32'hA5A5_0007, 1, 7, 7, 7, 1);
    idle(7, 7);
    step(0, 1, 0, 7, 32'h0, 0, 0, 7, 7, 1);
    idle(7, 7);

    // out-of-range index
    step(0, 1, 1, 20, 32'hFFFFFFFF, 0, 0, 20, 20, 1);
    step(0, 0, 0, 0, '0, 1, 20, 20, 15, 1);
    idle(20, 15);

    // writeback to a non-busy register
    step(0, 1, 1, 11, 32'h0BAD_F00D, 0, 0, 11, 0, 1);
    idle(11, 0);

    // reset mid-operation
    step(0, 0, 0, 0, '0, 1, 3, 3, 4, 1);
    step(0, 1, 1, 3, 32'h3333_3333, 1, 4, 3, 4, 1);
    step(0, 0, 0, 0, '0, 1, 9, 9, 3, 1);
    step(0, 0, 0, 0, '0, 1, 3, 3, 4, 1);
    step(1, 1, 1, 3, 32'h7777_7777, 1, 10, 3, 4, 1);
    idle(3, 9);
    idle(4, 5);

    for (int k = 0; k < 3000; k++) begin
      bit r, wv, we, iv;
      int wa, rd, a1, a2;
      r  = ($urandom_range(0, 63) == 0);
      wv = $urandom_range(0, 1) == 1;
      we = $urandom_range(0, 3) != 0;
      iv = $urandom_range(0, 1) == 1;
      wa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 17));
      rd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 17));
      a1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? rd : int'($urandom_range(0, 17));
      step(r, wv, we, wa, $urandom, iv, rd, a1, a2, 1);
    end

    step(0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    cmp("queue_drained", DW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpr_wb_scoreboard.md
Name: gpr_wb_scoreboard

Overview:
- General-purpose register file and writeback receiver for the NPC core.
- Sits at the far end of the execute unit's write interface (wen/waddr/wdata). It accepts writebacks through a valid/ready handshake and provides two read ports, with same-cycle bypass, to the decode stage.
- Keeps a per-register pending (busy) scoreboard. Decode sets a pending bit at issue; writeback clears it.

Parameters:
- REG_ADDR_WIDTH, 5, width of register index.
- DATA_WIDTH, 32, register width.
- NR_REGS, 32, implemented registers. Legal values: 32 (RV32I) or 16 (RV32E).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- wb_valid  input  1  writeback request valid
- wb_ready  output  1  writeback can be accepted
- wb_wen  input  1  writeback carries register data
- wb_waddr  input  REG_ADDR_WIDTH  writeback destination index
- wb_wdata  input  DATA_WIDTH  writeback data
- iss_valid  input  1  decode issues an instruction with destination iss_rd
- iss_rd  input  REG_ADDR_WIDTH  destination to mark pending
- iss_ready  output  1  issue accepted this cycle
- rs1_addr  input  REG_ADDR_WIDTH  read port 1 index
- rs1_data  output  DATA_WIDTH  read port 1 data
- rs1_busy  output  1  rs1 has an outstanding write
- rs2_addr  input  REG_ADDR_WIDTH  read port 2 index
- rs2_data  output  DATA_WIDTH  read port 2 data
- rs2_busy  output  1  rs2 has an outstanding write
- pending_cnt  output  REG_ADDR_WIDTH+1  number of set busy bits

Behaviour:
- Reset (rst high at posedge):
  - All registers are cleared to 0.
  - All busy bits are cleared to 0 and pending_cnt is 0.
  - wb_ready and iss_ready are 0 while rst is high and 1 otherwise, subject to the issue rule below.
- Writeback handshake:
  - wb_fire = wb_valid & wb_ready.
  - When wb_fire & wb_wen & wb_waddr != 0 & wb_waddr < NR_REGS, reg[wb_waddr] takes wb_wdata at the posedge. Write latency is 1 cycle.
  - When wb_fire & wb_waddr != 0, busy[wb_waddr] is cleared, whether or not wb_wen is set.
- Address legality:
  - Index 0 is hardwired to zero. Writes to it are ignored and it is never busy.
  - Indices >= NR_REGS read as 0, are ignored on write, and are never busy.
- Reads are combinational.
  - rsX_data is 0 for index 0 or an out-of-range index.
  - Otherwise, if wb_fire & wb_wen & wb_waddr == rsX_addr this cycle, rsX_data is wb_wdata (bypass).
  - Otherwise rsX_data is reg[rsX_addr].
- Busy outputs:
  - rsX_busy = busy[rsX_addr] & ~(wb_fire & wb_waddr == rsX_addr).
  - Clearing is therefore visible in the same cycle as the writeback.
- Issue handshake:
  - iss_ready = ~rst & ~(iss_rd legal & nonzero & busy[iss_rd] & ~(wb_fire & wb_waddr == iss_rd)).
  - Only one outstanding write per register is allowed (WAW stall).
  - iss_fire = iss_valid & iss_ready. When iss_fire & iss_rd legal & nonzero, busy[iss_rd] is set at the posedge.
  - Issue to rd 0 or to an out-of-range rd fires and sets nothing.
- Simultaneous set and clear on the same index in one cycle: set wins, so busy is 1 afterwards.
- pending_cnt is a registered counter updated each cycle:
  - +1 when a bit is newly set.
  - -1 when a bit is cleared.
  - Unchanged when both happen on the same index, or when both happen on different indices.
  - Never wraps: maximum is NR_REGS-1, minimum is 0.
  - pending_cnt must always equal the popcount of the busy vector.
- Reset mid-operation: a writeback or issue presented in a reset cycle has no effect. All state takes its reset value.
- A writeback to a non-busy register is legal: the data is written and busy stays 0.

Test Plan:
- Reset, then read all indices -> rs1_data = rs2_data = 0, both busy = 0, pending_cnt = 0, wb_ready = 1 the cycle after rst falls.
- Issue rd=5, then writeback wen=1 waddr=5 wdata=0xDEADBEEF with rs1_addr=5 in the same cycle:
  - -> rs1_busy = 1 before the writeback.
  - -> in the writeback cycle rs1_data = 0xDEADBEEF via bypass and rs1_busy = 0.
  - -> the next cycle reg[5] = 0xDEADBEEF and pending_cnt returns 1 -> 0.
- Writeback wen=1 waddr=0 wdata=0x12345678 -> rs2_addr=0 reads 0. Issue rd=0 -> iss_ready = 1 and pending_cnt stays 0.
- Issue rd=7 twice: second issue in a later cycle -> iss_ready = 0. Second issue in the same cycle as the writeback to 7 -> iss_ready = 1, busy[7] stays 1, pending_cnt stays 1.
- NR_REGS=16: writeback waddr=20 wdata=0xFFFFFFFF -> rs1_addr=20 reads 0. Issue rd=20 -> pending_cnt stays 0.
- Issue rd=3, rd=4, rd=9 -> pending_cnt = 3. Assert rst with wb_valid=1 waddr=3 -> afterwards all busy = 0, pending_cnt = 0, reg[3] = 0.
